// File: rtl/sd_resp_rx.sv
// sd_resp_rx: host-side SD CMD-line response receiver for 48-bit and 136-bit (R2) frames.
// Define SD_RESP_CRC_EN to build the CRC7 checker; without it ocrc_err is tied to 0.
module sd_resp_rx #(
    parameter int NCR_MAX = 64,
    parameter int CNT_W   = 8
) (
    input  logic         iclk,
    input  logic         irst,
    input  logic         isd_rise,
    input  logic         icmd,
    input  logic         istart,
    input  logic         ilong,
    output logic         obusy,
    output logic         odone,
    output logic [5:0]   oidx,
    output logic [31:0]  oarg,
    output logic [119:0] olong_data,
    output logic         ocrc_err,
    output logic         oframe_err,
    output logic         otimeout
);
    typedef enum logic [1:0] {IDLE, WAIT_START, RECV, DONE} state_t;

    localparam logic [CNT_W-1:0] NCR_C = CNT_W'(NCR_MAX);

    state_t           state_q, state_d;
    logic             long_q, long_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [119:0]     shift_q, shift_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             frame_err_q, frame_err_d;
    logic             timeout_q, timeout_d;
    logic [5:0]       idx_q, idx_d;
    logic [31:0]      arg_q, arg_d;
    logic [119:0]     long_data_q, long_data_d;
    logic [CNT_W-1:0] bit_n, last_bit, data_end, crc_lo;
`ifdef SD_RESP_CRC_EN
    logic [6:0]       crc_q, crc_d;
    logic [6:0]       rx_crc_q, rx_crc_d;
    logic             crc_err_q, crc_err_d;
    logic             fb;
`endif

    // bit_n is the 1-based position of the bit sampled on this strobe; the start bit is bit 1
    always_comb begin
        bit_n       = cnt_q + CNT_W'(1);
        last_bit    = long_q ? CNT_W'(136) : CNT_W'(48);
        data_end    = long_q ? CNT_W'(128) : CNT_W'(40);
        crc_lo      = long_q ? CNT_W'(9) : CNT_W'(2);
        state_d     = state_q;
        long_d      = long_q;
        cnt_d       = cnt_q;
        shift_d     = shift_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        frame_err_d = frame_err_q;
        timeout_d   = timeout_q;
        idx_d       = idx_q;
        arg_d       = arg_q;
        long_data_d = long_data_q;
`ifdef SD_RESP_CRC_EN
        crc_d       = crc_q;
        rx_crc_d    = rx_crc_q;
        crc_err_d   = crc_err_q;
        fb          = icmd ^ crc_q[6];
`endif
        case (state_q)
            IDLE: begin
                if (istart) begin
                    state_d     = WAIT_START;
                    long_d      = ilong;
                    busy_d      = 1'b1;
                    cnt_d       = '0;
                    frame_err_d = 1'b0;
                    timeout_d   = 1'b0;
`ifdef SD_RESP_CRC_EN
                    crc_err_d   = 1'b0;
`endif
                end
            end
            WAIT_START: begin
                if (isd_rise) begin
                    if (!icmd) begin
                        state_d = RECV;
                        cnt_d   = CNT_W'(1);
`ifdef SD_RESP_CRC_EN
                        crc_d   = '0;
`endif
                    end else begin
                        cnt_d = bit_n;
                        if (bit_n == NCR_C) begin
                            state_d   = DONE;
                            timeout_d = 1'b1;
                            done_d    = 1'b1;
                            busy_d    = 1'b0;
                        end
                    end
                end
            end
            RECV: begin
                if (isd_rise) begin
                    cnt_d = bit_n;
                    if (bit_n <= data_end) shift_d = {shift_q[118:0], icmd};
                    if (bit_n == CNT_W'(2) && icmd) frame_err_d = 1'b1;
`ifdef SD_RESP_CRC_EN
                    if (bit_n >= crc_lo && bit_n <= data_end)
                        crc_d = {crc_q[5:3], crc_q[2] ^ fb, crc_q[1:0], fb};
                    if (bit_n > data_end && bit_n < last_bit) rx_crc_d = {rx_crc_q[5:0], icmd};
`endif
                    if (bit_n == last_bit) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        if (!icmd) frame_err_d = 1'b1;
                        if (long_q) begin
                            long_data_d = shift_q;
                            idx_d       = 6'h3F;
                        end else begin
                            idx_d = shift_q[37:32];
                            arg_d = shift_q[31:0];
                        end
`ifdef SD_RESP_CRC_EN
                        crc_err_d = crc_q != rx_crc_q;
`endif
                    end
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge iclk) begin
        if (!irst) begin
            state_q     <= IDLE;
            long_q      <= 1'b0;
            cnt_q       <= '0;
            shift_q     <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            frame_err_q <= 1'b0;
            timeout_q   <= 1'b0;
            idx_q       <= '0;
            arg_q       <= '0;
            long_data_q <= '0;
`ifdef SD_RESP_CRC_EN
            crc_q       <= '0;
            rx_crc_q    <= '0;
            crc_err_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            long_q      <= long_d;
            cnt_q       <= cnt_d;
            shift_q     <= shift_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            frame_err_q <= frame_err_d;
            timeout_q   <= timeout_d;
            idx_q       <= idx_d;
            arg_q       <= arg_d;
            long_data_q <= long_data_d;
`ifdef SD_RESP_CRC_EN
            crc_q       <= crc_d;
            rx_crc_q    <= rx_crc_d;
            crc_err_q   <= crc_err_d;
`endif
        end
    end

    assign obusy      = busy_q;
    assign odone      = done_q;
    assign oidx       = idx_q;
    assign oarg       = arg_q;
    assign olong_data = long_data_q;
    assign oframe_err = frame_err_q;
    assign otimeout   = timeout_q;
`ifdef SD_RESP_CRC_EN
    assign ocrc_err   = crc_err_q;
`else
    assign ocrc_err   = 1'b0;
`endif
endmodule

// File: doc/sd_resp_rx.md
Name: sd_resp_rx

Overview:
- Host-side receiver for SD card responses on the CMD line.
- It is the return path of the command transmitter: it is armed after a command is sent, then hunts for the start bit and shifts in a 48-bit (R1/R3/R6/R7) or 136-bit (R2) response.
- It checks CRC7, transmission and end bits, and presents index/argument or CID/CSD content to the SD controller FSM in ghost_sd.

Parameters:
- NCR_MAX, 64, maximum SD clock periods from arming to start bit before timeout.
- CNT_W, 8, width of the timeout and bit counters; must satisfy 2^CNT_W > max(NCR_MAX, 136).

Ports:
- iclk  input  1  system clock (36 MHz).
- irst  input  1  synchronous active-low reset.
- isd_rise  input  1  one-iclk strobe marking an SD CLK rising edge; CMD is sampled only on this strobe.
- icmd  input  1  CMD line input (synchronised externally, pulled up when idle).
- istart  input  1  arm pulse; accepted only in IDLE.
- ilong  input  1  1 = expect a 136-bit R2 response; latched with istart.
- obusy  output  1  high from an accepted istart until odone.
- odone  output  1  one-iclk pulse when reception ends (success, error or timeout).
- oidx  output  6  response index (short responses); 6'h3F for R2.
- oarg  output  32  argument field (short responses).
- olong_data  output  120  CID/CSD bits [127:8] (R2).
- ocrc_err  output  1  CRC7 mismatch; valid with odone.
- oframe_err  output  1  transmission bit not 0 or end bit not 1; valid with odone.
- otimeout  output  1  no start bit within NCR_MAX strobes; valid with odone.

Behaviour:
- Reset (irst=0 at a clock edge) puts the FSM in IDLE and zeroes every output and counter. Reset mid-reception aborts it with no odone.
- All sampling and advancement happen only on iclk edges where isd_rise=1, except the DONE→IDLE step.
- States and transitions:
  - IDLE: on istart=1, latch ilong, clear error flags, set obusy=1, clear the timeout counter, go to WAIT_START. istart in any other state is ignored.
  - WAIT_START: on each strobe, if icmd=0, go to RECV with bit count=1. Otherwise increment the timeout counter; on reaching NCR_MAX, set otimeout=1 and go to DONE. The start bit itself is not CRC'd.
  - RECV: shift icmd into the shift register MSB-first. Bit 2 is the transmission bit; 1 sets oframe_err (reception continues).
    - Short frame: bits 2..40 feed CRC7; bits 41..47 are the received CRC; bit 48 is the end bit.
    - Long frame: bits 3..8 are reserved and not CRC'd; bits 9..128 feed CRC7; bits 129..135 are CRC; bit 136 is the end bit.
    - After the end bit, go to DONE. End bit=0 sets oframe_err.
  - DONE: update oidx/oarg (short) or olong_data plus oidx=6'h3F (long) from the shift register; set ocrc_err if the computed CRC differs from the received one; pulse odone for exactly one iclk; clear obusy; go to IDLE on the next iclk regardless of isd_rise.
- CRC7: polynomial x^7+x^3+1, register initialised to 0 at the start bit, updated serially per strobe.
- Data outputs hold their values until the next DONE.
- On timeout, data outputs are left unchanged and ocrc_err=oframe_err=0.
- Latency: odone is asserted 1 iclk after the strobe that samples the end bit.
- If isd_rise and istart coincide in IDLE, the arm is accepted; that strobe is not sampled.

Optional Feature:
- SD_RESP_CRC_EN
  - Defined: CRC7 logic is instantiated and ocrc_err behaves as above.
  - Undefined: CRC logic is omitted, the CRC field is shifted in and discarded, and ocrc_err is constant 0. Intended for R3-only bring-up builds.

Test Plan:
- Short frame: after istart, ilong=0, drive 5 idle-high strobes then frame 0x08_000001AA with the correct CRC7 from the bench model and end bit 1. Expect odone once, oidx=6'h08, oarg=32'h000001AA, all error flags 0, and odone exactly 1 iclk after the end-bit strobe.
- Transmission-bit error: drive frame 0x40_00000000_95 (transmission bit 1). Expect oframe_err=1, oidx=6'h00, ocrc_err per the bench model.
- Timeout: keep icmd=1 for 64 strobes after arming. Expect odone with otimeout=1, obusy falling on the same edge, and oidx/oarg unchanged.
- R2 frame: ilong=1, drive a 136-bit frame with content 120'h0123…EF and a valid CRC. Expect olong_data equal to the content, oidx=6'h3F, no errors. Repeat with one content bit flipped: expect ocrc_err=1 (or 0 when SD_RESP_CRC_EN is undefined).
- Reset mid-frame: drive irst=0 for one iclk at bit 20. Expect all outputs 0, no odone, and a subsequent valid short frame received correctly.
- Bad end bit plus ignored re-arm: end bit driven 0 → oframe_err=1. A second istart pulse during RECV has no effect: exactly one odone.
